// File: rtl/comparator_pkg.sv
// comparator_pkg: shared result/status types and the per-chunk resolve function.
package comparator_pkg;
  localparam int MAX_CHUNK = 32;
  typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_res_t;
  typedef struct packed {
    logic decided;
    logic lt;
    logic gt;
  } status_t;
  function automatic status_t chunk_cmp(input status_t st, input logic [MAX_CHUNK-1:0] ca, input logic [MAX_CHUNK-1:0] cb);
    return (!st.decided && ca != cb) ? status_t'{decided: 1'b1, lt: ca < cb, gt: ca > cb} : st;
  endfunction
endpackage

// File: rtl/comparator_pipe_if.sv
// comparator_pipe_if: operand/result stream handshake bundle.
interface comparator_pipe_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, is_signed, out_valid, out_ready, alb, aeb, agb;
  logic [WIDTH-1:0] a, b;
  modport master(output in_valid, a, b, is_signed, out_ready, input in_ready, out_valid, alb, aeb, agb);
  modport slave(input in_valid, a, b, is_signed, out_ready, output in_ready, out_valid, alb, aeb, agb);
endinterface

// File: rtl/comparator_pipe_cmp_stage.sv
// cmp_stage: resolves one chunk into the running status and registers it, holding on stall.
module cmp_stage import comparator_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX = 0,
  parameter bit TOP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             v_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  status_t          st_i,
  output logic             v_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output status_t          st_q
);
  logic v_d;
  logic [WIDTH-1:0] a_d, b_d;
  status_t st_d;
  logic [CHUNK-1:0] ca, cb, flip;
  // Inverting the sign bit of the top chunk maps two's-complement order onto unsigned order.
  always_comb begin
    flip = '0;
    flip[CHUNK-1] = TOP && sgn_i;
    ca = a_i[IDX*CHUNK +: CHUNK] ^ flip;
    cb = b_i[IDX*CHUNK +: CHUNK] ^ flip;
    v_d = hold ? v_q : v_i;
    a_d = hold ? a_q : a_i;
    b_d = hold ? b_q : b_i;
    st_d = hold ? st_q : chunk_cmp(st_i, MAX_CHUNK'(ca), MAX_CHUNK'(cb));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      st_q <= '0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
      b_q <= b_d;
      st_q <= st_d;
    end
  end
endmodule

// File: rtl/comparator_pipe.sv
// comparator_pipe: pipelined MSB-first magnitude comparator with saturating result counters.
module comparator_pipe import comparator_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  comparator_pipe_if.slave   io,
  input  logic               clr,
  output logic [CNT_W-1:0]   cnt_lt,
  output logic [CNT_W-1:0]   cnt_eq,
  output logic [CNT_W-1:0]   cnt_gt
);
  localparam int CH = CHUNK < 1 ? 1 : CHUNK;
  localparam int NST = WIDTH / CH;
  if (CHUNK < 1 || CHUNK > MAX_CHUNK || WIDTH % CH != 0) begin : g_bad
    $error("comparator_pipe: WIDTH must be a multiple of CHUNK, CHUNK in 1..%0d", MAX_CHUNK);
  end
  logic stall, deliver;
  logic v [NST];
  logic [WIDTH-1:0] a_s [NST];
  logic [WIDTH-1:0] b_s [NST];
  status_t st [NST];
  cmp_res_t res;
  logic [CNT_W-1:0] cnt_lt_d, cnt_eq_d, cnt_gt_d, cnt_lt_q, cnt_eq_q, cnt_gt_q;
  for (genvar k = 0; k < NST; k++) begin : g_st
    logic vi;
    logic [WIDTH-1:0] ai, bi;
    status_t sti;
    if (k == 0) begin : g_in
      assign vi = io.in_valid;
      assign ai = io.a;
      assign bi = io.b;
      assign sti = '0;
    end else begin : g_in
      assign vi = v[k-1];
      assign ai = a_s[k-1];
      assign bi = b_s[k-1];
      assign sti = st[k-1];
    end
    cmp_stage #(.WIDTH(WIDTH), .CHUNK(CH), .IDX(NST-1-k), .TOP(k == 0)) u_stage (
      .clk(clk), .rst_n(rst_n), .hold(stall), .v_i(vi), .sgn_i(io.is_signed),
      .a_i(ai), .b_i(bi), .st_i(sti),
      .v_q(v[k]), .a_q(a_s[k]), .b_q(b_s[k]), .st_q(st[k])
    );
  end
  assign stall = v[NST-1] && !io.out_ready;
  assign io.in_ready = !stall;
  assign io.out_valid = v[NST-1];
  assign io.alb = io.out_valid && res == CMP_LT;
  assign io.aeb = io.out_valid && res == CMP_EQ;
  assign io.agb = io.out_valid && res == CMP_GT;
  assign cnt_lt = cnt_lt_q;
  assign cnt_eq = cnt_eq_q;
  assign cnt_gt = cnt_gt_q;
  // A status still undecided after the last chunk means the operands are equal.
  always_comb begin
    res = st[NST-1].lt ? CMP_LT : st[NST-1].gt ? CMP_GT : CMP_EQ;
    deliver = io.out_valid && io.out_ready;
    cnt_lt_d = clr ? '0 : cnt_lt_q + CNT_W'(deliver && res == CMP_LT && cnt_lt_q != '1);
    cnt_eq_d = clr ? '0 : cnt_eq_q + CNT_W'(deliver && res == CMP_EQ && cnt_eq_q != '1);
    cnt_gt_d = clr ? '0 : cnt_gt_q + CNT_W'(deliver && res == CMP_GT && cnt_gt_q != '1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lt_q <= '0;
      cnt_eq_q <= '0;
      cnt_gt_q <= '0;
    end else begin
      cnt_lt_q <= cnt_lt_d;
      cnt_eq_q <= cnt_eq_d;
      cnt_gt_q <= cnt_gt_d;
    end
  end
endmodule
